// File: rtl/knn_pkg.sv
// Shared types and constants for the dual-lane KNN query scheduler.
// Pulled in by knn_lane_seq and knn_query_scheduler via import knn_pkg::*.
package knn_pkg;

    localparam int COORD_W = 8;
    localparam int CLASS_W = 2;
    localparam int DIST_W  = 18;

    localparam logic KMODE_K3 = 1'b0;
    localparam logic KMODE_K5 = 1'b1;

    typedef logic [2:0] top_state_t;
    typedef logic [1:0] lane_state_t;

    localparam top_state_t ST_IDLE      = 3'd0;
    localparam top_state_t ST_CLEAR     = 3'd1;
    localparam top_state_t ST_SCAN      = 3'd2;
    localparam top_state_t ST_WAIT_VOTE = 3'd3;
    localparam top_state_t ST_RESULT    = 3'd4;

    localparam lane_state_t L_FETCH = 2'd0;
    localparam lane_state_t L_RUN   = 2'd1;
    localparam lane_state_t L_DONE  = 2'd2;

endpackage

// File: rtl/knn_lane_seq.sv
// Per-lane fetch/run/done sequencer: walks ROM addresses BASE, BASE+2, ... below NUM_POINTS.
// Optional per-lane done watchdog when KNN_WATCHDOG_EN is defined.
module knn_lane_seq
    import knn_pkg::*;
#(
    parameter int NUM_POINTS      = 64,
    parameter int ADDR_W          = 8,
    parameter int BASE            = 0,
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic              done_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              start_o,
    output logic              sort_valid_o,
    output logic              lane_done_o,
    output logic              wd_trip_o
);

    lane_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_q;
    logic [ADDR_W:0]   addr_step;

    // One extra bit so the end-of-scan compare holds even when NUM_POINTS == 2**ADDR_W.
    assign addr_step = {1'b0, addr_q} + (ADDR_W+1)'(2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (load_i) begin
            state_d = L_FETCH;
            addr_d  = ADDR_W'(BASE);
        end else if (abort_i) begin
            state_d = L_DONE;
        end else begin
            case (state_q)
                L_FETCH: state_d = L_RUN;
                L_RUN: begin
                    if (done_i) begin
                        if (addr_step < (ADDR_W+1)'(NUM_POINTS)) begin
                            state_d = L_FETCH;
                            addr_d  = addr_step[ADDR_W-1:0];
                        end else begin
                            state_d = L_DONE;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= L_DONE;
            addr_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= (state_d == L_RUN) && (state_q != L_RUN);
        end
    end

    assign addr_o       = addr_q;
    assign start_o      = start_q;
    assign sort_valid_o = (state_q == L_RUN) && done_i && !abort_i;
    assign lane_done_o  = (state_q == L_DONE);

`ifdef KNN_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_q;

    // Cleared outside L_RUN, so every new start begins a fresh count.
    always_ff @(posedge clk) begin
        if (rst || state_q != L_RUN) begin
            wd_q <= '0;
        end else if (wd_q != WD_W'(WATCHDOG_CYCLES)) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_trip_o = (state_q == L_RUN) && !done_i && (wd_q == WD_W'(WATCHDOG_CYCLES - 1));
`else
    // Watchdog compiled out: the lane waits for done indefinitely.
    assign wd_trip_o = (WATCHDOG_CYCLES < 0);
`endif

endmodule

// File: rtl/knn_query_scheduler.sv
// Query scheduler for the dual-lane KNN datapath: accept, scan both lanes, await vote, return result.
// KNN_WATCHDOG_EN enables the per-lane done watchdog (inside knn_lane_seq) that aborts with res_err.
module knn_query_scheduler
    import knn_pkg::*;
#(
    parameter int NUM_POINTS      = 64,
    parameter int ADDR_W          = 8,
    parameter int CYC_W           = 16,
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [COORD_W-1:0] q_x,
    input  logic [COORD_W-1:0] q_y,
    input  logic               q_mode,
    output logic [COORD_W-1:0] x_in,
    output logic [COORD_W-1:0] y_in,
    output logic               mode,
    output logic [ADDR_W-1:0]  even_addr,
    output logic [ADDR_W-1:0]  odd_addr,
    output logic               start_even,
    output logic               start_odd,
    input  logic               done_even,
    input  logic               done_odd,
    output logic               sort_valid_even,
    output logic               sort_valid_odd,
    output logic               sort_clear,
    input  logic               vote_done,
    input  logic [CLASS_W-1:0] vote_class,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLASS_W-1:0] res_class,
    output logic [CYC_W-1:0]   res_cycles,
    output logic               res_err,
    output logic               busy
);

    top_state_t         state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic               mode_q;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic [CYC_W-1:0]   rcyc_q, rcyc_d;
    logic               err_q, err_d;

    logic accept, abort;
    logic lane_done_even, lane_done_odd;
    logic trip_even, trip_odd;

    assign accept = (state_q == ST_IDLE) && q_valid;
    assign abort  = (state_q == ST_SCAN) && (trip_even || trip_odd);

    knn_lane_seq #(
        .NUM_POINTS      (NUM_POINTS),
        .ADDR_W          (ADDR_W),
        .BASE            (0),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_lane_even (
        .clk          (clk),
        .rst          (rst),
        .load_i       (accept),
        .abort_i      (abort),
        .done_i       (done_even),
        .addr_o       (even_addr),
        .start_o      (start_even),
        .sort_valid_o (sort_valid_even),
        .lane_done_o  (lane_done_even),
        .wd_trip_o    (trip_even)
    );

    knn_lane_seq #(
        .NUM_POINTS      (NUM_POINTS),
        .ADDR_W          (ADDR_W),
        .BASE            (1),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_lane_odd (
        .clk          (clk),
        .rst          (rst),
        .load_i       (accept),
        .abort_i      (abort),
        .done_i       (done_odd),
        .addr_o       (odd_addr),
        .start_o      (start_odd),
        .sort_valid_o (sort_valid_odd),
        .lane_done_o  (lane_done_odd),
        .wd_trip_o    (trip_odd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        rcyc_d  = rcyc_q;
        err_d   = err_q;

        // Latency counts CLEAR through WAIT_VOTE and sticks at all-ones.
        if ((state_q == ST_CLEAR || state_q == ST_SCAN || state_q == ST_WAIT_VOTE) && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (q_valid) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: state_d = ST_SCAN;
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_RESULT;
                    cls_d   = '0;
                    rcyc_d  = cnt_q;
                    err_d   = 1'b1;
                end else if (lane_done_even && lane_done_odd) begin
                    state_d = ST_WAIT_VOTE;
                end
            end
            ST_WAIT_VOTE: begin
                if (vote_done) begin
                    state_d = ST_RESULT;
                    cls_d   = vote_class;
                    rcyc_d  = cnt_q;
                    err_d   = 1'b0;
                end
            end
            ST_RESULT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            cls_q   <= '0;
            rcyc_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            rcyc_q  <= rcyc_d;
            err_q   <= err_d;
            if (accept) begin
                x_q    <= q_x;
                y_q    <= q_y;
                mode_q <= q_mode;
            end
        end
    end

    assign q_ready    = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign sort_clear = (state_q == ST_CLEAR);
    assign res_valid  = (state_q == ST_RESULT);
    assign res_class  = cls_q;
    assign res_cycles = rcyc_q;
    assign res_err    = err_q;
    assign x_in       = x_q;
    assign y_in       = y_q;
    assign mode       = mode_q;

endmodule

// File: doc/knn_query_scheduler.md
Name: knn_query_scheduler

Overview:
- Controller for the dual-lane KNN datapath: two distance engines (even/odd), two top-k sorters, merge sort, majority voter.
- Accepts a query point (x, y, K-mode) over a valid/ready handshake and scans all NUM_POINTS ROM entries, split into an even lane and an odd lane.
- Issues ROM addresses and distance-engine start pulses, and gates sorter valid_in.
- Waits for the voter result and returns class plus latency over a second valid/ready handshake. This replaces the hardcoded query and free-running address logic.

Parameters:
- NUM_POINTS, 64, number of dataset entries in ROM; minimum 2.
- ADDR_W, 8, ROM address width.
- CYC_W, 16, width of the latency counter.
- WATCHDOG_CYCLES, 1023, maximum cycles a lane waits for engine done. Used only with KNN_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- q_valid  in  1  query offered
- q_ready  out  1  scheduler can accept a query
- q_x  in  8  query x coordinate
- q_y  in  8  query y coordinate
- q_mode  in  1  0 = K3, 1 = K5
- x_in  out  8  registered query x to both engines
- y_in  out  8  registered query y to both engines
- mode  out  1  registered K-mode to voter
- even_addr  out  ADDR_W  even-lane ROM address
- odd_addr  out  ADDR_W  odd-lane ROM address
- start_even  out  1  one-cycle start to even engine
- start_odd  out  1  one-cycle start to odd engine
- done_even  in  1  even engine result valid
- done_odd  in  1  odd engine result valid
- sort_valid_even  out  1  even sorter valid_in
- sort_valid_odd  out  1  odd sorter valid_in
- sort_clear  out  1  one-cycle re-init pulse to sorters, merge and voter
- vote_done  in  1  voter result valid
- vote_class  in  2  voter predicted class
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  2  predicted class
- res_cycles  out  CYC_W  cycles from query accept to vote_done
- res_err  out  1  query aborted by watchdog
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. q_ready=1. All other outputs 0: x_in, y_in, mode, even_addr, odd_addr, starts, sort_valids, sort_clear, res_*, busy.
- Reset mid-operation aborts the query immediately; no result is produced.
- Top FSM: IDLE -> CLEAR -> SCAN -> WAIT_VOTE -> RESULT -> IDLE.
- IDLE:
  - q_ready=1.
  - On q_valid, register q_x/q_y/q_mode into x_in/y_in/mode. These hold stable until the next accept.
  - Clear the cycle counter and go to CLEAR.
- CLEAR (1 cycle):
  - sort_clear=1.
  - even_addr=0, odd_addr=1.
  - Both lanes enter L_FETCH. Go to SCAN.
- Lane sequencer, one per lane, independent. States L_FETCH, L_RUN, L_DONE.
  - L_FETCH (1 cycle): address stable for the synchronous ROM read. Next state L_RUN.
  - L_RUN entry cycle: start_x=1 for exactly 1 cycle. The lane then waits for done_x.
  - Cycle with done_x in L_RUN: sort_valid_x = done_x, combinational, same cycle. Address += 2. If new address < NUM_POINTS go to L_FETCH, else L_DONE.
  - done_x outside L_RUN is ignored.
  - Even lane visits ceil(N/2) points; odd lane visits floor(N/2).
- SCAN: go to WAIT_VOTE when both lanes are in L_DONE. The lanes may finish in either order.
- WAIT_VOTE:
  - vote_done is sampled only in this state; earlier pulses are ignored.
  - On vote_done, latch res_class=vote_class, res_cycles=counter, res_err=0. Go to RESULT.
- RESULT:
  - res_valid=1 with res_class, res_cycles and res_err held until res_ready.
  - On res_ready, go to IDLE. q_ready rises the following cycle; no same-cycle result/accept overlap.
- Cycle counter:
  - Starts at 0 in the CLEAR cycle and increments each cycle through WAIT_VOTE inclusive.
  - Saturates at all-ones; no wrap.
- Arithmetic: address increment done in ADDR_W+1 bits so the comparison never wraps, including NUM_POINTS = 2^ADDR_W.

Optional Feature:
- KNN_WATCHDOG_EN defined:
  - Per-lane counter runs in L_RUN and resets on each start.
  - If it reaches WATCHDOG_CYCLES without done, both lanes are forced to L_DONE and the FSM goes to RESULT, skipping WAIT_VOTE.
  - Result fields: res_err=1, res_class=0, res_cycles=counter.
- Undefined: no counters; res_err tied 0; a lane waits indefinitely.

Decomposition:
- Shared package knn_pkg:
  - COORD_W=8, CLASS_W=2, DIST_W=18.
  - Top-state and lane-state enums.
  - K-mode encoding constants.
- One natural sub-module, knn_lane_seq: the fetch/run/done sequencer with address stepping by 2, base address parameter, and the optional watchdog. Instantiated twice, with base 0 and base 1.

Test Plan:
- NUM_POINTS=8, engine model asserting done 3 cycles after start, query (198,127,K5):
  - even addrs 0,2,4,6 and odd addrs 1,3,5,7, each followed by exactly 1 start and 1 sort_valid.
  - One sort_clear precedes the first start.
  - Voter model returns 2 -> res_class=2, res_err=0, res_cycles equals the bench-counted cycles.
- NUM_POINTS=7: even lane issues 4 starts, odd lane 3. WAIT_VOTE is entered only after the odd lane's third done and the even lane's fourth done.
- Lane skew (odd latency 2, even latency 6): lanes advance independently; no start occurs outside L_RUN entry; a vote_done injected during SCAN is ignored.
- res_ready held low 10 cycles: res_valid, res_class and res_cycles stay stable; q_ready=0; q_valid pulses are not accepted. After res_ready, q_ready=1 the next cycle.
- rst asserted mid-SCAN: next cycle all outputs are 0 and the FSM is IDLE. The following query restarts at addresses 0 and 1 with new x_in/y_in.
- KNN_WATCHDOG_EN, WATCHDOG_CYCLES=16, done_odd never returned: res_valid asserts with res_err=1 and res_class=0. No further starts are issued.
